// File: rtl/xor_tap_sequencer_if.sv
// Operand/result bus between the tap sequencer (master) and the shared sign-XOR unit (slave).
interface xor_tap_sequencer_if #(
    parameter int DQ_W  = 16,
    parameter int DQN_W = 11
);
    logic [DQ_W-1:0]  xor_dq;
    logic [DQN_W-1:0] xor_dqn;
    logic             xor_vld;
    logic             xor_un;

    modport master (output xor_dq, output xor_dqn, output xor_vld, input xor_un);
    modport slave  (input xor_dq, input xor_dqn, input xor_vld, output xor_un);
endinterface

// File: rtl/xor_tap_sequencer.sv
// Time-shares one sign-XOR unit across TAPS predictor taps, collects Un per tap, then shifts DQn history.
// Optional: define XOR_TAP_ZERO_SKIP_EN to bypass the XOR sequence when dq magnitude is zero.
module xor_tap_sequencer #(
    parameter int TAPS    = 6,
    parameter int DQ_W    = 16,
    parameter int DQN_W   = 11,
    parameter int XOR_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DQ_W-1:0]    dq,
    input  logic [DQN_W-1:0]   dq_flt,
    xor_tap_sequencer_if.master xbus,
    output logic [TAPS-1:0]    un_vec,
    output logic               busy,
    output logic               done
);

    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(TAPS - 1);
    localparam logic [1:0]       LAST_DRAIN = 2'(XOR_LAT - 1);
    localparam logic [DQN_W-1:0] HIST_RST = DQN_W'('h020);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, UPDATE} state_t;

    state_t            state_reg;
    logic [DQ_W-1:0]   dq_reg;
    logic [DQN_W-1:0]  dq_flt_reg;
    logic [DQN_W-1:0]  xor_dqn_reg;
    logic              xor_vld_reg;
    logic [IW-1:0]     idx_reg;
    logic [IW-1:0]     idx_next;
    logic [1:0]        drain_reg;
    logic [TAPS-1:0]   un_vec_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [DQN_W-1:0]  hist_reg  [TAPS];
    logic [DQN_W-1:0]  hist_next [TAPS];
    logic              cap_vld;
    logic [IW-1:0]     cap_idx;
    logic              zero_mag;

`ifdef XOR_TAP_ZERO_SKIP_EN
    assign zero_mag = (dq[DQ_W-2:0] == '0);
`else
    assign zero_mag = 1'b0;
`endif

    assign idx_next = idx_reg + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            dq_reg      <= '0;
            dq_flt_reg  <= '0;
            xor_dqn_reg <= '0;
            xor_vld_reg <= 1'b0;
            idx_reg     <= '0;
            drain_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dq_reg     <= dq;
                        dq_flt_reg <= dq_flt;
                        busy_reg   <= 1'b1;
                        idx_reg    <= '0;
                        if (zero_mag) begin
                            state_reg <= UPDATE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg   <= ISSUE;
                            xor_vld_reg <= 1'b1;
                            xor_dqn_reg <= hist_reg[0];
                        end
                    end
                end
                ISSUE: begin
                    if (idx_reg == LAST_IDX) begin
                        xor_vld_reg <= 1'b0;
                        xor_dqn_reg <= '0;
                        drain_reg   <= '0;
                        if (XOR_LAT > 0) begin
                            state_reg <= DRAIN;
                        end else begin
                            state_reg <= UPDATE;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        idx_reg     <= idx_next;
                        xor_dqn_reg <= hist_reg[idx_next];
                    end
                end
                DRAIN: begin
                    if (drain_reg == LAST_DRAIN) begin
                        state_reg <= UPDATE;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_reg <= drain_reg + 2'd1;
                    end
                end
                UPDATE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Delay each issue's valid and tap index so late results land on the right bit.
    generate
        if (XOR_LAT > 0) begin : g_pipe
            logic [XOR_LAT-1:0] pv_reg;
            logic [IW-1:0]      pi_reg [XOR_LAT];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pv_reg <= '0;
                    for (int i = 0; i < XOR_LAT; i++) pi_reg[i] <= '0;
                end else begin
                    pv_reg[0] <= xor_vld_reg;
                    pi_reg[0] <= idx_reg;
                    for (int i = 1; i < XOR_LAT; i++) begin
                        pv_reg[i] <= pv_reg[i-1];
                        pi_reg[i] <= pi_reg[i-1];
                    end
                end
            end

            assign cap_vld = pv_reg[XOR_LAT-1];
            assign cap_idx = pi_reg[XOR_LAT-1];
        end else begin : g_nopipe
            assign cap_vld = xor_vld_reg;
            assign cap_idx = idx_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            un_vec_reg <= '0;
        end else begin
            if (state_reg == IDLE && start) un_vec_reg <= '0;
            if (cap_vld) un_vec_reg[cap_idx] <= xbus.xor_un;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_next[gi] = dq_flt_reg;
            end else begin : g_tail
                assign hist_next[gi] = hist_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) hist_reg[i] <= HIST_RST;
        end else if (state_reg == UPDATE) begin
            hist_reg <= hist_next;
        end
    end

    assign xbus.xor_dq  = dq_reg;
    assign xbus.xor_dqn = xor_dqn_reg;
    assign xbus.xor_vld = xor_vld_reg;
    assign un_vec       = un_vec_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_xor_tap_sequencer.sv
// Scoreboard bench for xor_tap_sequencer: stimulus queues expected un_vec/done cycle, a monitor checks each done.
module tb_xor_tap_sequencer;
    localparam int TAPS  = 6;
    localparam int DQ_W  = 16;
    localparam int DQN_W = 11;
    parameter  int LAT   = 1;
`ifdef XOR_TAP_ZERO_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [DQ_W-1:0]  dq = '0;
    logic [DQN_W-1:0] dq_flt = '0;
    logic [TAPS-1:0]  un_vec;
    logic             busy;
    logic             done;

    xor_tap_sequencer_if #(.DQ_W(DQ_W), .DQN_W(DQN_W)) xbus ();

    xor_tap_sequencer #(.TAPS(TAPS), .DQ_W(DQ_W), .DQN_W(DQN_W), .XOR_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .dq(dq), .dq_flt(dq_flt),
        .xbus(xbus), .un_vec(un_vec), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // XOR unit model: sign XOR, or a fixed per-tap result table to prove index-based capture.
    logic            use_tab = 1'b0;
    logic [TAPS-1:0] tab = '0;
    int              icnt = 0;
    logic [3:0]      rpipe = '0;
    logic            resp_now;

    always_comb begin
        resp_now = xbus.xor_dq[15] ^ xbus.xor_dqn[10];
        if (use_tab && icnt < TAPS) resp_now = tab[icnt];
    end
    always @(posedge clk) begin
        icnt  <= xbus.xor_vld ? icnt + 1 : 0;
        rpipe <= {rpipe[2:0], resp_now};
    end
    assign xbus.xor_un = (LAT == 0) ? resp_now : rpipe[(LAT == 0) ? 0 : LAT - 1];

    typedef struct packed {
        logic [TAPS-1:0] un;
        int              cyc;
    } exp_t;
    exp_t sb[$];

    logic [DQN_W-1:0] mh [TAPS];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle count %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_un_vec", 32'(un_vec), 32'(e.un));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
            $display("txn: done at %0d un_vec=%b", cyc, un_vec);
        end
    end

    task automatic hist_reset();
        for (int k = 0; k < TAPS; k++) mh[k] = 11'h020;
    endtask

    task automatic expect_run(input logic [15:0] d, input logic [10:0] f, input bit ut,
                              input logic [TAPS-1:0] t, input int c0,
                              output bit sk, output logic [TAPS-1:0] e);
        sk = SKIP_EN && (d[14:0] == 15'd0);
        for (int k = 0; k < TAPS; k++) e[k] = sk ? 1'b0 : (ut ? t[k] : (d[15] ^ mh[k][10]));
        sb.push_back('{un: e, cyc: c0 + (sk ? 1 : TAPS + LAT + 1)});
        for (int k = TAPS - 1; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = f;
    endtask

    task automatic run(input logic [15:0] d, input logic [10:0] f, input bit ut, input logic [TAPS-1:0] t);
        logic [DQN_W-1:0] pre [TAPS];
        logic [TAPS-1:0]  e;
        bit               sk;
        int               n_end;
        pre = mh;
        expect_run(d, f, ut, t, cyc, sk, e);
        $display("txn: start dq=%h dq_flt=%h expect un_vec=%b skip=%0d", d, f, e, sk);
        use_tab = ut; tab = t; dq = d; dq_flt = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_end = sk ? 1 : TAPS + LAT + 1;
        for (int n = 1; n <= n_end; n++) begin
            chk("busy_run", 32'(busy), 32'd1);
            if (!sk && n <= TAPS) begin
                chk("vld_issue", 32'(xbus.xor_vld), 32'd1);
                chk("dqn_issue", 32'(xbus.xor_dqn), 32'(pre[n-1]));
                chk("dq_issue", 32'(xbus.xor_dq), 32'(d));
            end else begin
                chk("vld_quiet", 32'(xbus.xor_vld), 32'd0);
            end
            @(negedge clk);
        end
        chk("busy_idle", 32'(busy), 32'd0);
        chk("dqn_idle", 32'(xbus.xor_dqn), 32'd0);
        chk("dq_hold", 32'(xbus.xor_dq), 32'(d));
        chk("un_hold", 32'(un_vec), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [TAPS-1:0] e;
        bit sk;
        int c0;
        hist_reset();
        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(xbus.xor_vld), 32'd0);
        chk("rst_dq", 32'(xbus.xor_dq), 32'd0);
        chk("rst_dqn", 32'(xbus.xor_dqn), 32'd0);
        chk("rst_un", 32'(un_vec), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run(16'h8005, 11'h421, 1'b0, '0);           // expect 111111
        run(16'h0003, 11'h005, 1'b0, '0);           // expect 000001
        run(16'h0007, 11'h055, 1'b1, 6'b101101);    // table results by index

        // start held high: accepts only in cycles 0, 9, 18
        c0 = cyc;
        for (int r = 0; r < 3; r++) expect_run(16'h8001, 11'h400, 1'b0, '0, c0 + 9 * r, sk, e);
        use_tab = 1'b0; dq = 16'h8001; dq_flt = 11'h400; start = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            @(negedge clk);
            if (n == 27) start = 1'b0;
            if (n == 9 || n == 18 || n == 27) chk("held_gap_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        chk("held_no_extra", 32'(busy), 32'd0);

        // reset in cycle 4 of a run
        dq = 16'h8005; dq_flt = 11'h7ff; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_vld", 32'(xbus.xor_vld), 32'd0);
        chk("midrst_dq", 32'(xbus.xor_dq), 32'd0);
        chk("midrst_dqn", 32'(xbus.xor_dqn), 32'd0);
        chk("midrst_un", 32'(un_vec), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        $display("txn: reset asserted mid-run");
        hist_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run(16'h8005, 11'h123, 1'b0, '0);           // all taps read 11'h020 again

        run(16'h8000, 11'h222, 1'b0, '0);           // zero magnitude
        run(16'h0001, 11'h000, 1'b0, '0);           // sees shifted history

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
